// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Package  : router_pkg
// Brief    : Packet type codes, transmitter source selects and scheduler
//            state encoding shared by the router control logic.
// Revision : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam logic [2:0] c_PKT_ACK  = 3'b000;
    localparam logic [2:0] c_PKT_NACK = 3'b011;

    localparam logic [2:0] c_TX_ACK   = 3'd0;
    localparam logic [2:0] c_TX_TOKEN = 3'd3;
    localparam logic [2:0] c_TX_NEW   = 3'd4;

    typedef logic [2:0] sched_state_t;

    localparam sched_state_t c_ST_IDLE         = 3'd0;
    localparam sched_state_t c_ST_WAIT_TX      = 3'd1;
    localparam sched_state_t c_ST_LAUNCH       = 3'd2;
    localparam sched_state_t c_ST_WAIT_RESP    = 3'd3;
    localparam sched_state_t c_ST_TOKEN_WAIT   = 3'd4;
    localparam sched_state_t c_ST_TOKEN_LAUNCH = 3'd5;

    // Transmitter source implied by each scheduler state.
    function automatic logic [2:0] tx_select_for(input sched_state_t st);
        logic [2:0] sel;
        case (st)
            c_ST_WAIT_TX,
            c_ST_LAUNCH,
            c_ST_WAIT_RESP:    sel = c_TX_NEW;
            c_ST_TOKEN_WAIT,
            c_ST_TOKEN_LAUNCH: sel = c_TX_TOKEN;
            default:           sel = c_TX_ACK;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_retry_sched_if.sv
`default_nettype none
// ============================================================================
// Interface : tx_retry_sched_if
// Brief     : Control, transmitter and receiver handshake bundle of the
//             retry scheduler.
// Revision  : 1.0 - initial release
// ============================================================================
interface tx_retry_sched_if;

    logic       start_req;
    logic       tx_ready;
    logic       rx_has_data;
    logic [2:0] data_type;

    logic       tx_start;
    logic [2:0] tx_data_select;
    logic       busy;
    logic       done;
    logic       fail;
    logic       token_release;
    logic [2:0] retry_count;

    modport master (
        output start_req, tx_ready, rx_has_data, data_type,
        input  tx_start, tx_data_select, busy, done, fail, token_release, retry_count
    );

    modport slave (
        input  start_req, tx_ready, rx_has_data, data_type,
        output tx_start, tx_data_select, busy, done, fail, token_release, retry_count
    );

endinterface
`default_nettype wire

// File: rtl/resp_timer.sv
`default_nettype none
// ============================================================================
// Module   : resp_timer
// Brief    : 8-bit load/decrement response timer that stops at zero.
// Revision : 1.0 - initial release
// ============================================================================
module resp_timer #(
    parameter logic [7:0] LOAD_VALUE = 8'd200
) (
    input  wire logic Clk_R,
    input  wire logic Rst,
    input  wire logic i_load,
    input  wire logic i_enable,
    output logic      o_zero
);

    logic [7:0] r_count;

    always_ff @(posedge Clk_R or posedge Rst) begin
        if (Rst) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= LOAD_VALUE;
        end else if (i_enable && (r_count != 8'd0)) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_zero = (r_count == 8'd0);

endmodule
`default_nettype wire

// File: rtl/tx_retry_sched.sv
`default_nettype none
// ============================================================================
// Module   : tx_retry_sched
// Brief    : Launches the node packet, waits for ACK/NACK with timeout,
//            retransmits up to MAX_RETRY times, then releases the token.
// Revision : 1.0 - initial release
// ============================================================================
module tx_retry_sched
    import router_pkg::*;
#(
    parameter int         MAX_RETRY   = 3,
    parameter logic [7:0] ACK_TIMEOUT = 8'd200
) (
    input wire logic         Clk_R,
    input wire logic         Rst,
    tx_retry_sched_if.slave  bus
);

    localparam logic [2:0] c_MAX_RETRY = 3'(MAX_RETRY);

    sched_state_t r_state;
    sched_state_t w_state_next;

    logic [2:0] r_retry_count;
    logic       r_done;
    logic       r_fail;

    logic w_retry_clr;
    logic w_retry_inc;
    logic w_done_set;
    logic w_fail_set;
    logic w_can_retry;
    logic w_is_ack;
    logic w_is_nack;
    logic w_timer_zero;
    logic w_timer_load;
    logic w_timer_en;

    logic       w_tx_start;
    logic       w_token_release;
    logic       w_busy;
    logic [2:0] w_tx_sel;

    assign w_is_ack     = bus.rx_has_data && (bus.data_type == c_PKT_ACK);
    assign w_is_nack    = bus.rx_has_data && (bus.data_type == c_PKT_NACK);
    assign w_timer_load = (r_state == c_ST_LAUNCH);
    assign w_timer_en   = (r_state == c_ST_WAIT_RESP);

    // With no retries allowed the compare would be constant-false.
    generate
        if (MAX_RETRY == 0) begin : g_no_retry
            assign w_can_retry = 1'b0;
        end else begin : g_retry_cmp
            assign w_can_retry = (r_retry_count < c_MAX_RETRY);
        end
    endgenerate

    resp_timer #(
        .LOAD_VALUE (ACK_TIMEOUT)
    ) u_resp_timer (
        .Clk_R    (Clk_R),
        .Rst      (Rst),
        .i_load   (w_timer_load),
        .i_enable (w_timer_en),
        .o_zero   (w_timer_zero)
    );

    always_ff @(posedge Clk_R or posedge Rst) begin
        if (Rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_retry_clr  = 1'b0;
        w_retry_inc  = 1'b0;
        w_done_set   = 1'b0;
        w_fail_set   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.start_req) begin
                    w_state_next = c_ST_WAIT_TX;
                    w_retry_clr  = 1'b1;
                end
            end
            c_ST_WAIT_TX: begin
                if (bus.tx_ready) begin
                    w_state_next = c_ST_LAUNCH;
                end
            end
            c_ST_LAUNCH: begin
                w_state_next = c_ST_WAIT_RESP;
            end
            c_ST_WAIT_RESP: begin
                // ACK wins over a coincident timeout.
                if (w_is_ack) begin
                    w_state_next = c_ST_TOKEN_WAIT;
                    w_done_set   = 1'b1;
                end else if (w_is_nack || w_timer_zero) begin
                    if (w_can_retry) begin
                        w_state_next = c_ST_WAIT_TX;
                        w_retry_inc  = 1'b1;
                    end else begin
                        w_state_next = c_ST_TOKEN_WAIT;
                        w_fail_set   = 1'b1;
                    end
                end
            end
            c_ST_TOKEN_WAIT: begin
                if (bus.tx_ready) begin
                    w_state_next = c_ST_TOKEN_LAUNCH;
                end
            end
            c_ST_TOKEN_LAUNCH: begin
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_R or posedge Rst) begin
        if (Rst) begin
            r_retry_count <= 3'd0;
            r_done        <= 1'b0;
            r_fail        <= 1'b0;
        end else begin
            r_done <= w_done_set;
            r_fail <= w_fail_set;
            if (w_retry_clr) begin
                r_retry_count <= 3'd0;
            end else if (w_retry_inc) begin
                r_retry_count <= r_retry_count + 3'd1;
            end
        end
    end

    always_comb begin
        w_tx_start      = 1'b0;
        w_token_release = 1'b0;
        w_busy          = (r_state != c_ST_IDLE);
        w_tx_sel        = tx_select_for(r_state);
        case (r_state)
            c_ST_LAUNCH: begin
                w_tx_start = 1'b1;
            end
            c_ST_TOKEN_LAUNCH: begin
                w_tx_start      = 1'b1;
                w_token_release = 1'b1;
            end
            default: begin
                w_tx_start = 1'b0;
            end
        endcase
    end

    assign bus.tx_start       = w_tx_start;
    assign bus.token_release  = w_token_release;
    assign bus.busy           = w_busy;
    assign bus.tx_data_select = w_tx_sel;
    assign bus.done           = r_done;
    assign bus.fail           = r_fail;
    assign bus.retry_count    = r_retry_count;

endmodule
`default_nettype wire

// File: doc/tx_retry_sched.md
TX_RETRY_SCHED -- requirements
Module: tx_retry_sched

Interface
REQ-001 Parameter MAX_RETRY, default 3, meaning max retransmissions after the first attempt (legal 0..7).
REQ-002 Parameter ACK_TIMEOUT, default 8'd200, meaning cycles to wait for ACK/NACK after launch (legal 1..255).
REQ-003 Clk_R  input  1  router clock; all state changes on rising edge.
REQ-004 Rst  input  1  asynchronous, active-high reset.
REQ-005 start_req  input  1  control FSM holds token and node packet is loaded in tx buffer.
REQ-006 tx_ready  input  1  transmitter idle and able to accept a launch.
REQ-007 rx_has_data  input  1  receiver holds a decoded packet this cycle.
REQ-008 data_type  input  3  decoded packet type; ACK=3'b000, NACK=3'b011, others ignored.
REQ-009 tx_start  output  1  one-cycle launch pulse to transmitter.
REQ-010 tx_data_select  output  3  transmitter source select; tx_ACK=0 idle, tx_TOKEN=3, tx_NEW=4.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse: packet acknowledged.
REQ-013 fail  output  1  one-cycle pulse: retries exhausted.
REQ-014 token_release  output  1  one-cycle pulse coincident with token launch.
REQ-015 retry_count  output  3  retransmissions issued for current packet.

Function
REQ-016 States SHALL be IDLE, WAIT_TX, LAUNCH, WAIT_RESP, TOKEN_WAIT, TOKEN_LAUNCH; all outputs registered or decoded from registered state only.
REQ-017 IDLE: start_req=1 -> WAIT_TX, retry_count cleared to 0; start_req SHALL be ignored in all other states.
REQ-018 WAIT_TX: tx_ready=1 -> LAUNCH, else hold; tx_data_select=tx_NEW.
REQ-019 LAUNCH: tx_start=1, tx_data_select=tx_NEW for exactly one cycle; response timer loaded with ACK_TIMEOUT; -> WAIT_RESP unconditionally.
REQ-020 WAIT_RESP: timer decrements by 1 per cycle; tx_data_select=tx_NEW.
REQ-021 WAIT_RESP, rx_has_data=1 and data_type=ACK -> TOKEN_WAIT, done pulse in next cycle.
REQ-022 WAIT_RESP, (rx_has_data=1 and data_type=NACK) or timer=0 -> if retry_count<MAX_RETRY: retry_count+1, -> WAIT_TX; else fail pulse in next cycle, -> TOKEN_WAIT.
REQ-023 ACK and timer=0 in the same cycle SHALL resolve as ACK.
REQ-024 rx_has_data with any other data_type in WAIT_RESP SHALL be ignored; timer keeps running.
REQ-025 TOKEN_WAIT: tx_ready=1 -> TOKEN_LAUNCH; tx_data_select=tx_TOKEN.
REQ-026 TOKEN_LAUNCH: tx_start=1, token_release=1, tx_data_select=tx_TOKEN for one cycle; -> IDLE.
REQ-027 Latency: start_req sampled in IDLE with tx_ready held high SHALL give tx_start exactly 2 cycles later.
REQ-028 retry_count SHALL saturate at MAX_RETRY, never wrap; it holds its value in IDLE until the next start_req.
REQ-029 Timer SHALL be 8 bits, SHALL not decrement below 0, and SHALL only count in WAIT_RESP.
REQ-030 MAX_RETRY=0: first NACK/timeout SHALL produce fail with no retransmission.

Reset
REQ-031 Rst=1 SHALL immediately force IDLE, timer=0, retry_count=0, tx_start=0, busy=0, done=0, fail=0, token_release=0, tx_data_select=tx_ACK, including mid-packet.
REQ-032 After reset deassertion, no launch SHALL occur without a new start_req.

Structure
REQ-033 Packet type codes, tx_data_select codes and the state encoding SHALL live in shared package router_pkg, also used by control logic.
REQ-034 The response timer SHALL be a sub-module resp_timer (load, enable, zero flag).

Verification
REQ-035 start_req=1, tx_ready=1, ACK 5 cycles after tx_start -> one tx_start(NEW), done, then tx_start(TOKEN)+token_release, retry_count=0.
REQ-036 Three NACKs then ACK with MAX_RETRY=3 -> four NEW launches, done=1, fail never, retry_count=3.
REQ-037 No response, ACK_TIMEOUT=10, MAX_RETRY=1 -> launches 11 cycles apart (plus WAIT_TX), then fail and token launch.
REQ-038 ACK arriving on the timer=0 cycle -> done, no retransmission; tx_ready low 20 cycles in TOKEN_WAIT -> token held, released when tx_ready rises.
REQ-039 Rst asserted in WAIT_RESP, then released -> all outputs at reset values, busy=0, no tx_start until new start_req.
